// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Brief   : Shared state encoding, port identifiers and default limits.
// Revision: 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } arb_port_t;

    localparam int c_TIMEOUT_DEFAULT    = 16;
    localparam int c_FAIR_LIMIT_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_if
// Brief   : Fetch port, data port and memory-side bus of the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    // The arbiter sits on the slave side: it receives requests and answers them.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_ack, if_rdata, d_ack, d_rdata, err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_ack, if_rdata, d_ack, d_rdata, err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/arb_timer.sv
`default_nettype none
// ============================================================================
// Module  : arb_timer
// Brief   : Access wait counter; expired flags the last allowed wait cycle.
// Revision: 1.0 - initial release
// ============================================================================
module arb_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int c_CW = $clog2(TIMEOUT + 1);

    logic [c_CW-1:0] r_count;

    // Holding at the terminal value keeps expired asserted instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == c_CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one memory port between fetch and data with starvation cap.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = c_TIMEOUT_DEFAULT,
    parameter int FAIR_LIMIT = c_FAIR_LIMIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);
    localparam int c_FW = $clog2(FAIR_LIMIT + 1);

    arb_state_t    r_state,     w_state_nxt;
    arb_port_t     r_grant,     w_grant_nxt;
    logic [c_FW-1:0] r_fair_cnt, w_fair_nxt;
    logic          r_mem_en,    w_mem_en_nxt;
    logic          r_mem_we,    w_mem_we_nxt;
    logic [AW-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic          r_if_ack,    w_if_ack_nxt;
    logic [DW-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic          r_d_ack,     w_d_ack_nxt;
    logic [DW-1:0] r_d_rdata,   w_d_rdata_nxt;
    logic          r_err,       w_err_nxt;
    logic [DW-1:0] w_resp_rdata;
    logic          w_fair_full;
    logic          w_fetch_forced;
    logic          w_timer_clear;
    logic          w_timer_en;
    logic          w_expired;

    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_timer_clear),
        .enable  (w_timer_en),
        .expired (w_expired)
    );

    assign w_fair_full    = (r_fair_cnt == c_FW'(FAIR_LIMIT));
    assign w_fetch_forced = w_fair_full && bus.if_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant     <= PORT_FETCH;
            r_fair_cnt  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_d_ack     <= 1'b0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_fair_cnt  <= w_fair_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_ack    <= w_if_ack_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_ack     <= w_d_ack_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_fair_nxt      = r_fair_cnt;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_ack_nxt    = 1'b0;
        w_if_rdata_nxt  = '0;
        w_d_ack_nxt     = 1'b0;
        w_d_rdata_nxt   = '0;
        w_err_nxt       = 1'b0;
        w_resp_rdata    = '0;
        w_timer_clear   = 1'b0;
        w_timer_en      = 1'b0;

        case (r_state)
            IDLE: begin
                w_timer_clear = 1'b1;
                if (bus.d_req && !w_fetch_forced) begin
                    w_grant_nxt     = PORT_DATA;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = bus.d_we;
                    w_mem_addr_nxt  = bus.d_addr;
                    w_mem_wdata_nxt = bus.d_wdata;
                    // Only data grants that make fetch wait count toward the cap.
                    if (!bus.if_req) begin
                        w_fair_nxt = '0;
                    end else if (!w_fair_full) begin
                        w_fair_nxt = r_fair_cnt + 1'b1;
                    end
                    w_state_nxt = ACCESS;
                end else if (bus.if_req) begin
                    w_grant_nxt     = PORT_FETCH;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = bus.if_addr;
                    w_mem_wdata_nxt = '0;
                    w_fair_nxt      = '0;
                    w_state_nxt     = ACCESS;
                end
            end
            ACCESS: begin
                w_timer_en = 1'b1;
                // A ready on the final wait cycle still counts as a normal completion.
                if (bus.mem_ready || w_expired) begin
                    w_mem_en_nxt = 1'b0;
                    w_err_nxt    = !bus.mem_ready;
                    if (bus.mem_ready && !r_mem_we) begin
                        w_resp_rdata = bus.mem_rdata;
                    end
                    if (r_grant == PORT_DATA) begin
                        w_d_ack_nxt   = 1'b1;
                        w_d_rdata_nxt = w_resp_rdata;
                    end else begin
                        w_if_ack_nxt   = 1'b1;
                        w_if_rdata_nxt = w_resp_rdata;
                    end
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_ack    = r_if_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameters: AW, 32, address width; DW, 32, data width; TIMEOUT, 16, max cycles waiting for mem_ready; FAIR_LIMIT, 4, max consecutive data grants while fetch waits.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1  instruction-fetch read request; held until if_ack.
REQ-005 if_addr  in  AW  fetch word address.
REQ-006 if_ack  out  1  one-cycle completion pulse for fetch.
REQ-007 if_rdata  out  DW  fetched word; valid while if_ack=1.
REQ-008 d_req  in  1  data-port request; held until d_ack.
REQ-009 d_we  in  1  1 = store, 0 = load.
REQ-010 d_addr  in  AW  data address.
REQ-011 d_wdata  in  DW  store data.
REQ-012 d_ack  out  1  one-cycle completion pulse for data.
REQ-013 d_rdata  out  DW  load data; valid while d_ack=1.
REQ-014 err  out  1  one-cycle pulse coincident with ack when the access timed out.
REQ-015 mem_en  out  1  memory access strobe.
REQ-016 mem_we  out  1  memory write enable.
REQ-017 mem_addr  out  AW  memory address.
REQ-018 mem_wdata  out  DW  memory write data.
REQ-019 mem_rdata  in  DW  memory read data, valid when mem_ready=1.
REQ-020 mem_ready  in  1  memory access complete.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, RESP; all outputs registered.
REQ-022 IDLE: if any req sampled high, SHALL latch winner's addr/we/wdata onto mem_* outputs, assert mem_en, go to ACCESS; else stay.
REQ-023 Arbitration SHALL be fixed priority data over fetch, except when fair_cnt = FAIR_LIMIT and if_req=1, then fetch wins.
REQ-024 fair_cnt SHALL increment on each data grant while if_req=1, saturate at FAIR_LIMIT, and clear on any fetch grant or any data grant with if_req=0.
REQ-025 Fetch grants SHALL drive mem_we=0 and mem_wdata=0.
REQ-026 ACCESS: mem_* outputs SHALL remain stable; wait counter increments each cycle from 0.
REQ-027 ACCESS with mem_ready=1: SHALL capture mem_rdata (loads/fetch; 0 for stores) to the granted port's rdata, assert that port's ack, drop mem_en, go to RESP.
REQ-028 ACCESS with wait counter = TIMEOUT-1 and mem_ready=0: SHALL drop mem_en, assert ack and err, rdata=0, go to RESP.
REQ-029 RESP SHALL last exactly one cycle, then IDLE; ack/err deassert on leaving RESP.
REQ-030 Requests sampled in ACCESS or RESP SHALL be ignored; requester deasserting req mid-access SHALL NOT abort it (ack still issued).
REQ-031 Minimum latency: req sampled at edge k, mem_en high after k, mem_ready at edge k+1, ack high for cycle after k+1, next grant possible at edge k+3.
REQ-032 Non-granted port's ack and rdata SHALL stay 0.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, fair_cnt=0, wait counter=0, and all outputs 0 (mem_en, mem_we, mem_addr, mem_wdata, if_ack, if_rdata, d_ack, d_rdata, err).
REQ-034 Reset during ACCESS SHALL abandon the access with no ack; first grant possible at first edge after rst_n rises.

Structure
REQ-035 Shared package SHALL hold the state enum, default TIMEOUT and FAIR_LIMIT constants.
REQ-036 The wait counter with timeout compare SHALL be a sub-module arb_timer (clear, enable, expired).

Verification
REQ-037 Single fetch: if_req, if_addr=0x10, mem_ready 2 cycles later with 0xDEADBEEF -> if_ack one cycle, if_rdata=0xDEADBEEF, err=0.
REQ-038 Simultaneous: if_req and d_req (load 0x40) same edge -> data served first, then fetch; fair_cnt=1 then 0.
REQ-039 Starvation: d_req held for 5 accesses with if_req high -> grant order D,D,D,D,IF,D.
REQ-040 Timeout: d_req store 0x80/0x1234, mem_ready never -> d_ack and err high on cycle 17 after grant, mem_en low.
REQ-041 Reset mid-ACCESS: rst_n low during fetch -> mem_en low immediately, no if_ack, IDLE after release.
REQ-042 Req dropped mid-access: d_req falls in ACCESS -> access completes, d_ack still pulses.
